// File: rtl/tfe_seq_pkg.sv
// tfe_seq_pkg: shared opcode/state enums and header field positions for the command sequencer
package tfe_seq_pkg;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RSV_BIT = 4;
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_CLEAR   = 3'd2,
    OP_ACCUM   = 3'd3,
    OP_READOUT = 3'd4
  } tfe_op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_ACC,
    S_RD
  } tfe_seq_state_e;
endpackage

// File: rtl/tfe_seq_hdr_decode.sv
// tfe_seq_hdr_decode: combinational header split into opcode, len and illegal flag
// TFE_SEQ_ERR_EN makes a set reserved bit count as illegal; otherwise it is ignored.
module tfe_seq_hdr_decode
  import tfe_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic [DATA_W-1:0] hdr,
  output tfe_op_e           op,
  output logic [LEN_W-1:0]  len,
  output logic              illegal
);
`ifdef TFE_SEQ_ERR_EN
  localparam bit RSV_CHK = 1'b1;
`else
  localparam bit RSV_CHK = 1'b0;
`endif
  assign op = tfe_op_e'(hdr[OP_MSB:OP_LSB]);
  assign len = hdr[LEN_W-1:0];
  assign illegal = (hdr[OP_MSB:OP_LSB] > 3'd4) | (RSV_CHK & hdr[RSV_BIT]);
endmodule

// File: rtl/tfe_cmd_sequencer.sv
// tfe_cmd_sequencer: byte-stream command parser driving the MAC core strobes and data bus
// TFE_SEQ_ERR_EN enables the sticky err flag for illegal headers; undefined ties err to 0.
module tfe_cmd_sequencer
  import tfe_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] core_data,
  output logic              core_write,
  output logic              core_read,
  output logic              core_clear,
  output logic              core_accu_en,
  output logic              core_out_en,
  output logic              busy,
  output logic              err
);
  tfe_seq_state_e   state;
  logic [LEN_W-1:0] cnt;
  tfe_op_e          op;
  logic [LEN_W-1:0] len;
  logic             illegal;
  tfe_seq_hdr_decode #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_dec (
    .hdr     (in_data),
    .op      (op),
    .len     (len),
    .illegal (illegal)
  );
  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      core_data    <= '0;
      core_write   <= 1'b0;
      core_read    <= 1'b0;
      core_clear   <= 1'b0;
      core_accu_en <= 1'b0;
      core_out_en  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      core_write   <= 1'b0;
      core_read    <= 1'b0;
      core_clear   <= 1'b0;
      core_accu_en <= 1'b0;
      core_out_en  <= 1'b0;
      case (state)
        S_IDLE: if (in_valid && !illegal) begin
          case (op)
            OP_LOAD: begin
              state <= S_LOAD;
              cnt   <= len;
              busy  <= 1'b1;
            end
            OP_CLEAR: begin
              state      <= S_CLR;
              core_clear <= 1'b1;
              busy       <= 1'b1;
            end
            OP_ACCUM: begin
              state        <= S_ACC;
              cnt          <= len;
              core_read    <= 1'b1;
              core_accu_en <= 1'b1;
              busy         <= 1'b1;
            end
            OP_READOUT: begin
              state       <= S_RD;
              cnt         <= len;
              core_out_en <= 1'b1;
              busy        <= 1'b1;
            end
            default: ;
          endcase
        end
        S_LOAD: if (in_valid) begin
          core_data  <= in_data;
          core_write <= 1'b1;
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        S_CLR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_ACC: if (cnt == '0) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt          <= cnt - 1'b1;
          core_read    <= 1'b1;
          core_accu_en <= 1'b1;
        end
        S_RD: if (cnt == '0) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else begin
          cnt         <= cnt - 1'b1;
          core_out_en <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`ifdef TFE_SEQ_ERR_EN
  // illegal wins over CLEAR so a CLEAR header with the reserved bit set still flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == S_IDLE && in_valid && illegal) err <= 1'b1;
    else if (state == S_IDLE && in_valid && op == OP_CLEAR) err <= 1'b0;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tfe_cmd_sequencer.sv
// tb_tfe_cmd_sequencer: table-driven header vectors plus scoreboarded LOAD payloads
module tb_tfe_cmd_sequencer;
`ifdef TFE_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] core_data;
  logic       core_write, core_read, core_clear, core_accu_en, core_out_en, busy, err;
  tfe_cmd_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .core_data    (core_data),
    .core_write   (core_write),
    .core_read    (core_read),
    .core_clear   (core_clear),
    .core_accu_en (core_accu_en),
    .core_out_en  (core_out_en),
    .busy         (busy),
    .err          (err)
  );
  initial forever #5 clk = ~clk;
  typedef struct {
    logic [7:0] hdr;
    int         clr;
    int         acc;
    int         out;
    bit         err;
  } vec_t;
  vec_t       tv[12];
  int         checks = 0;
  int         errors = 0;
  int         n_wr = 0, n_clr = 0, n_acc = 0, n_rd = 0, n_out = 0, n_overlap = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         rd_ptr = 0;
  always @(negedge clk) begin
    if (core_write) begin
      n_wr++;
      obs_q.push_back(core_data);
    end
    n_clr += int'(core_clear);
    n_acc += int'(core_accu_en);
    n_rd  += int'(core_read);
    n_out += int'(core_out_en);
    if (int'(core_write) + int'(core_clear) + int'(core_accu_en) + int'(core_out_en) > 1 ||
        (core_read && !core_accu_en)) n_overlap++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit payload);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready0 expected=in_ready1 byte=%0h", b);
    end else if (payload) exp_q.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    while (rd_ptr < obs_q.size()) begin
      if (exp_q.size() == 0) chk("unexpected_write", {24'h0, obs_q[rd_ptr]}, 32'hFFFF_FFFF);
      else chk("wr_data", {24'h0, obs_q[rd_ptr]}, {24'h0, exp_q.pop_front()});
      rd_ptr++;
    end
    chk("sb_empty", exp_q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int b_wr, b_clr, b_acc, b_rd, b_out;
    tv[0]  = '{8'h00, 0, 0, 0, 1'b0};
    tv[1]  = '{8'h40, 1, 0, 0, 1'b0};
    tv[2]  = '{8'h60, 0, 1, 0, 1'b0};
    tv[3]  = '{8'h6F, 0, 16, 0, 1'b0};
    tv[4]  = '{8'h80, 0, 0, 1, 1'b0};
    tv[5]  = '{8'h85, 0, 0, 6, 1'b0};
    tv[6]  = '{8'hE0, 0, 0, 0, ERR_EN};
    tv[7]  = '{8'hA3, 0, 0, 0, ERR_EN};
    tv[8]  = '{8'h40, 1, 0, 0, 1'b0};
    tv[9]  = '{8'h50, int'(!ERR_EN), 0, 0, ERR_EN};
    tv[10] = '{8'h40, 1, 0, 0, 1'b0};
    tv[11] = '{8'h0F, 0, 0, 0, 1'b0};
    idle(3);
    chk("rst_core_data", core_data, 0);
    chk("rst_strobes", {core_write, core_read, core_clear, core_accu_en, core_out_en}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    b_wr = n_wr;
    send(8'h22, 0);
    send(8'h11, 1);
    send(8'h22, 1);
    send(8'h33, 1);
    @(negedge clk);
    chk("load_busy_drop", busy, 0);
    chk("load_last_write", core_write, 1);
    chk("load_last_data", core_data, 8'h33);
    idle(2);
    drain();
    chk("load_write_count", n_wr - b_wr, 3);
    send(8'h63, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("acc_en_%0d", k), core_accu_en, k <= 4);
      chk($sformatf("acc_rd_%0d", k), core_read, k <= 4);
      chk($sformatf("acc_ready_%0d", k), in_ready, k > 4);
    end
    idle(1);
    send(8'h40, 0);
    @(negedge clk);
    chk("clr_pulse", core_clear, 1);
    chk("clr_ready_n1", in_ready, 0);
    @(negedge clk);
    chk("clr_pulse_end", core_clear, 0);
    chk("clr_ready_n2", in_ready, 1);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      b_clr = n_clr; b_acc = n_acc; b_rd = n_rd; b_out = n_out; b_wr = n_wr;
      send(tv[i].hdr, 0);
      idle(20);
      chk($sformatf("tv%0d_clr", i), n_clr - b_clr, tv[i].clr);
      chk($sformatf("tv%0d_acc", i), n_acc - b_acc, tv[i].acc);
      chk($sformatf("tv%0d_read", i), n_rd - b_rd, tv[i].acc);
      chk($sformatf("tv%0d_out", i), n_out - b_out, tv[i].out);
      chk($sformatf("tv%0d_wr", i), n_wr - b_wr, 0);
      chk($sformatf("tv%0d_err", i), err, tv[i].err);
      chk($sformatf("tv%0d_busy", i), busy, 0);
    end
    b_wr = n_wr; b_out = n_out;
    send(8'h21, 0);
    idle(5);
    chk("gap_busy", busy, 1);
    send(8'hA5, 1);
    idle(5);
    send(8'h5A, 1);
    send(8'h80, 0);
    idle(5);
    drain();
    chk("gap_write_count", n_wr - b_wr, 2);
    chk("gap_out_count", n_out - b_out, 1);
    chk("gap_data_hold", core_data, 8'h5A);
    chk("gap_busy_end", busy, 0);
    chk("gap_overlap", n_overlap, 0);
    send(8'h6F, 0);
    repeat (3) @(negedge clk);
    chk("mid_acc_active", core_accu_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_accu", core_accu_en, 0);
    chk("async_read", core_read, 0);
    chk("async_busy", busy, 0);
    chk("async_data", core_data, 0);
    chk("async_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    b_clr = n_clr; b_acc = n_acc;
    send(8'h40, 0);
    @(negedge clk);
    chk("post_rst_hdr_clr", core_clear, 1);
    idle(3);
    chk("post_rst_no_acc", n_acc - b_acc, 0);
    chk("post_rst_clr_count", n_clr - b_clr, 1);
    chk("final_overlap", n_overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
